at_latch_load: RTL



---
 rtl/at_latch_load.sv | 76 +++++++
 1 files changed

// File: rtl/at_latch_load.sv
// Load sequencer for the AT latch bank: FIFO-buffered words, setup/strobe/wait handshake.
// Optional macro AT_LATCH_HOLD_EN inserts a quiet HOLD cycle between STROBE and WAIT.
module at_latch_load #(
  parameter int size  = 8,
  parameter int depth = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [size-1:0]       in_data,
  output logic                  in_ready,
  output logic [size-1:0]       out_d,
  output logic                  out_en,
  input  logic                  out_ack,
  output logic                  busy,
  output logic [$clog2(depth):0] count
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_count = (aw+1)'(depth);

`ifdef AT_LATCH_HOLD_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT} state_t;
`endif

  state_t          state;
  logic [size-1:0] mem [depth];
  logic [aw:0]     wr_ptr, rd_ptr, wr_next, rd_next;
  logic            push, pop, has_data;

  // Full check uses the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready = (count != full_count) & ~reset;
  assign push     = in_valid & in_ready;
  assign has_data = (count != '0);
  assign pop      = has_data & ((state == IDLE) | ((state == WAIT) & out_ack));
  assign busy     = (state != IDLE);
  assign wr_next  = wr_ptr + (aw+1)'(push);
  assign rd_next  = rd_ptr + (aw+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[aw-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_d  <= '0;
      out_en <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      count  <= wr_next - rd_next;
      out_en <= 1'b0;
      if (pop) out_d <= mem[rd_ptr[aw-1:0]];
      case (state)
        IDLE:   if (has_data) state <= SETUP;
        SETUP: begin
          state  <= STROBE;
          out_en <= 1'b1;
        end
`ifdef AT_LATCH_HOLD_EN
        STROBE: state <= HOLD;
        HOLD:   state <= WAIT;
`else
        STROBE: state <= WAIT;
`endif
        WAIT:   if (out_ack) state <= has_data ? SETUP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
